// File: rtl/mux_arb_rr_if.sv
// Bundle of requester and sink handshake signals for mux_arb_rr.
// The req_lck lane exists only when MUX_ARB_RR_LOCK_EN is defined.
interface mux_arb_rr_if #(
    parameter type DAT_T = logic [8-1:0],
    parameter int  WIDTH = 9
);
    localparam int IDX_W = $clog2(WIDTH);

    // valid/ready: a word moves on a rising clk edge when vld and rdy are both high;
    // vld and dat must hold until accepted, and vld must not depend on rdy.
    logic [WIDTH-1:0]       req_vld;
    DAT_T [WIDTH-1:0]       req_dat;
    logic [WIDTH-1:0]       req_rdy;
`ifdef MUX_ARB_RR_LOCK_EN
    logic [WIDTH-1:0]       req_lck;
`endif
    logic                   out_vld;
    DAT_T                   out_dat;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_rdy;

    modport master (
        output req_vld, req_dat, out_rdy,
`ifdef MUX_ARB_RR_LOCK_EN
        output req_lck,
`endif
        input  req_rdy, out_vld, out_dat, out_idx
    );

    modport slave (
        input  req_vld, req_dat, out_rdy,
`ifdef MUX_ARB_RR_LOCK_EN
        input  req_lck,
`endif
        output req_rdy, out_vld, out_dat, out_idx
    );
endinterface

// File: rtl/mux_arb_rr.sv
// Registered arbitrating mux: WIDTH requesters share one output slot, fixed-priority
// (MODE 0) or round-robin (MODE 1). Define MUX_ARB_RR_LOCK_EN for grant locking.
module mux_arb_rr #(
    parameter type      DAT_T = logic [8-1:0],
    parameter int       WIDTH = 9,
    parameter int       MODE  = 1,
    localparam int      IDX_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_arb_rr_if.slave bus
);

    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] elig;
    logic [IDX_W-1:0] gnt;
    logic             gnt_any;
    logic             slot_free;
    logic             xfer;

`ifdef MUX_ARB_RR_LOCK_EN
    logic             lck_act;
    logic [IDX_W-1:0] lck_idx;
`endif

    assign slot_free = !bus.out_vld || bus.out_rdy;

    // A held lock pins the grant to lck_idx even when that requester is idle.
    always_comb begin
        elig = bus.req_vld;
`ifdef MUX_ARB_RR_LOCK_EN
        if (lck_act) begin
            elig          = '0;
            elig[lck_idx] = 1'b1;
        end
`endif
    end

    always_comb begin : grant_scan
        int scan;
        gnt     = '0;
        gnt_any = 1'b0;
        scan    = 0;
        for (int k = 0; k < WIDTH; k++) begin
            scan = (MODE == 1) ? int'(ptr) + k : k;
            if (scan >= WIDTH) scan = scan - WIDTH;
            if (!gnt_any && elig[scan]) begin
                gnt_any = 1'b1;
                gnt     = IDX_W'(scan);
            end
        end
    end

    always_comb begin
        bus.req_rdy = '0;
        if (rst_n && slot_free && gnt_any) bus.req_rdy[gnt] = 1'b1;
    end

    assign xfer = bus.req_vld[gnt] && bus.req_rdy[gnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld <= 1'b0;
            bus.out_dat <= '0;
            bus.out_idx <= '0;
            ptr         <= '0;
        end else if (xfer) begin
            bus.out_vld <= 1'b1;
            bus.out_dat <= bus.req_dat[gnt];
            bus.out_idx <= gnt;
            if (MODE == 1) ptr <= (gnt == IDX_W'(WIDTH - 1)) ? '0 : gnt + IDX_W'(1);
        end else if (slot_free) begin
            bus.out_vld <= 1'b0;
        end
    end

`ifdef MUX_ARB_RR_LOCK_EN
    // While locked gnt always equals lck_idx, so a lck=0 transfer is the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lck_act <= 1'b0;
            lck_idx <= '0;
        end else if (xfer) begin
            if (bus.req_lck[gnt]) begin
                lck_act <= 1'b1;
                lck_idx <= gnt;
            end else if (lck_act && gnt == lck_idx) begin
                lck_act <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: one fixed-priority and one round-robin instance driven with
// identical stimulus; vector table, hand sequences and a randomized model comparison.
module tb_mux_arb_rr;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] req_vld;
  logic [W-1:0] req_lck;
  logic [W-1:0][7:0] req_dat;
  logic out_rdy;

  int checks = 0;
  int errors = 0;

  mux_arb_rr_if #(.DAT_T(logic [7:0]), .WIDTH(W)) if_fp ();
  mux_arb_rr_if #(.DAT_T(logic [7:0]), .WIDTH(W)) if_rr ();

  assign if_fp.req_vld = req_vld;
  assign if_fp.req_dat = req_dat;
  assign if_fp.out_rdy = out_rdy;
  assign if_rr.req_vld = req_vld;
  assign if_rr.req_dat = req_dat;
  assign if_rr.out_rdy = out_rdy;
`ifdef MUX_ARB_RR_LOCK_EN
  assign if_fp.req_lck = req_lck;
  assign if_rr.req_lck = req_lck;
`endif

  mux_arb_rr #(.DAT_T(logic [7:0]), .WIDTH(W), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(if_fp.slave));
  mux_arb_rr #(.DAT_T(logic [7:0]), .WIDTH(W), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr.slave));

  always #5 clk = ~clk;

  // ---------------- reference model (index 0 = fixed, 1 = round-robin) -----
  int         m_ptr[2];
  logic       m_vld[2];
  logic [7:0] m_dat[2];
  int         m_idx[2];
  logic       m_la[2];
  int         m_li[2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_vld[m] = 1'b0; m_dat[m] = '0;
      m_idx[m] = 0; m_la[m] = 1'b0; m_li[m] = 0;
    end
  endfunction

  // Winner = eligible index with the smallest distance from the priority origin.
  function automatic int model_grant(int m);
    int best;
    int best_d;
    best = -1;
    best_d = W;
    for (int i = 0; i < W; i++) begin
      logic e;
      int d;
      e = req_vld[i];
      if (m_la[m]) e = (i == m_li[m]);
      d = (m == 1) ? (i - m_ptr[m] + W) % W : i;
      if (e && d < best_d) begin
        best_d = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [W-1:0] model_rdy(int m);
    int g;
    g = model_grant(m);
    if (rst_n && (!m_vld[m] || out_rdy) && g >= 0) return W'(1) << g;
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_compare();
    check("fp_rdy", 32'(if_fp.req_rdy), 32'(model_rdy(0)));
    check("fp_vld", 32'(if_fp.out_vld), 32'(m_vld[0]));
    check("fp_idx", 32'(if_fp.out_idx), 32'(m_idx[0]));
    check("fp_dat", 32'(if_fp.out_dat), 32'(m_dat[0]));
    check("rr_rdy", 32'(if_rr.req_rdy), 32'(model_rdy(1)));
    check("rr_vld", 32'(if_rr.out_vld), 32'(m_vld[1]));
    check("rr_idx", 32'(if_rr.out_idx), 32'(m_idx[1]));
    check("rr_dat", 32'(if_rr.out_dat), 32'(m_dat[1]));
  endtask

  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      int g;
      logic [W-1:0] r;
      g = model_grant(m);
      r = model_rdy(m);
      if (r != '0 && req_vld[g]) begin
        m_vld[m] = 1'b1;
        m_dat[m] = req_dat[g];
        m_idx[m] = g;
        if (m == 1) m_ptr[m] = (g + 1) % W;
`ifdef MUX_ARB_RR_LOCK_EN
        if (req_lck[g]) begin
          m_la[m] = 1'b1;
          m_li[m] = g;
        end else if (m_la[m] && g == m_li[m]) begin
          m_la[m] = 1'b0;
        end
`endif
      end else if (!m_vld[m] || out_rdy) begin
        m_vld[m] = 1'b0;
      end
    end
  endfunction

  // Inputs are driven at negedge; settle lets combinational rdy resolve.
  task automatic settle();
    #1;
  endtask

  task automatic advance();
    model_compare();
    model_step();
    @(negedge clk);
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic [W-1:0] vld;
    logic         ordy;
    logic [W-1:0] rr_rdy;
    logic [W-1:0] fp_rdy;
    logic         ovld;
    int           rr_idx;
    int           fp_idx;
  } vec_t;

  vec_t tbl[16];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{9'h000, 1'b1, 9'h000, 9'h000, 1'b0, 0, 0};
    tbl[1]  = '{9'h1FF, 1'b1, 9'h001, 9'h001, 1'b0, 0, 0};
    tbl[2]  = '{9'h1FF, 1'b1, 9'h002, 9'h001, 1'b1, 0, 0};
    tbl[3]  = '{9'h1FF, 1'b0, 9'h000, 9'h000, 1'b1, 1, 0};
    tbl[4]  = '{9'h1FF, 1'b0, 9'h000, 9'h000, 1'b1, 1, 0};
    tbl[5]  = '{9'h104, 1'b1, 9'h004, 9'h004, 1'b1, 1, 0};
    tbl[6]  = '{9'h104, 1'b1, 9'h100, 9'h004, 1'b1, 2, 2};
    tbl[7]  = '{9'h104, 1'b1, 9'h004, 9'h004, 1'b1, 8, 2};
    tbl[8]  = '{9'h001, 1'b1, 9'h001, 9'h001, 1'b1, 2, 2};
    tbl[9]  = '{9'h000, 1'b1, 9'h000, 9'h000, 1'b1, 0, 0};
    tbl[10] = '{9'h000, 1'b0, 9'h000, 9'h000, 1'b0, 0, 0};
    tbl[11] = '{9'h100, 1'b0, 9'h100, 9'h100, 1'b0, 0, 0};
    tbl[12] = '{9'h080, 1'b1, 9'h080, 9'h080, 1'b1, 8, 8};
    tbl[13] = '{9'h001, 1'b1, 9'h001, 9'h001, 1'b1, 7, 7};
    tbl[14] = '{9'h003, 1'b1, 9'h002, 9'h001, 1'b1, 0, 0};
    tbl[15] = '{9'h000, 1'b1, 9'h000, 9'h000, 1'b1, 1, 0};

    req_vld = '0;
    req_lck = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < W; i++) req_dat[i] = 8'hA0 + 8'(i);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle
    for (int c = 0; c < 5; c++) begin
      settle();
      check("idle_fp_vld", 32'(if_fp.out_vld), 32'd0);
      check("idle_rr_vld", 32'(if_rr.out_vld), 32'd0);
      check("idle_rr_idx", 32'(if_rr.out_idx), 32'd0);
      check("idle_rr_rdy", 32'(if_rr.req_rdy), 32'd0);
      check("idle_fp_rdy", 32'(if_fp.req_rdy), 32'd0);
      advance();
    end

    // Table: priority, backpressure, wrap boundary
    for (int t = 0; t < 16; t++) begin
      req_vld = tbl[t].vld;
      out_rdy = tbl[t].ordy;
      settle();
      check("tbl_rr_rdy", 32'(if_rr.req_rdy), 32'(tbl[t].rr_rdy));
      check("tbl_fp_rdy", 32'(if_fp.req_rdy), 32'(tbl[t].fp_rdy));
      check("tbl_rr_vld", 32'(if_rr.out_vld), 32'(tbl[t].ovld));
      check("tbl_fp_vld", 32'(if_fp.out_vld), 32'(tbl[t].ovld));
      check("tbl_rr_idx", 32'(if_rr.out_idx), 32'(tbl[t].rr_idx));
      check("tbl_fp_idx", 32'(if_fp.out_idx), 32'(tbl[t].fp_idx));
      if (tbl[t].ovld) begin
        check("tbl_rr_dat", 32'(if_rr.out_dat), 32'(8'hA0 + 8'(tbl[t].rr_idx)));
        check("tbl_fp_dat", 32'(if_fp.out_dat), 32'(8'hA0 + 8'(tbl[t].fp_idx)));
      end
      advance();
    end

    // Reset while holding a word
    req_vld = 9'h001;
    out_rdy = 1'b1;
    settle();
    advance();
    check("pre_reset_rr_vld", 32'(if_rr.out_vld), 32'd1);
    rst_n = 1'b0;
    settle();
    check("reset_rr_vld", 32'(if_rr.out_vld), 32'd0);
    check("reset_fp_vld", 32'(if_fp.out_vld), 32'd0);
    check("reset_rr_rdy", 32'(if_rr.req_rdy), 32'd0);
    check("reset_rr_idx", 32'(if_rr.out_idx), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness, req_dat[i] = i
    for (int i = 0; i < W; i++) req_dat[i] = 8'(i);
    req_vld = '1;
    out_rdy = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      settle();
      check("rr_fair_rdy", 32'(if_rr.req_rdy), 32'(W'(1) << (k % W)));
      check("fp_fix_rdy", 32'(if_fp.req_rdy), 32'h001);
      if (k > 0) begin
        check("rr_fair_idx", 32'(if_rr.out_idx), 32'((k - 1) % W));
        check("rr_fair_dat", 32'(if_rr.out_dat), 32'((k - 1) % W));
        check("fp_fix_idx", 32'(if_fp.out_idx), 32'd0);
        check("fp_fix_dat", 32'(if_fp.out_dat), 32'd0);
      end
      advance();
    end

    // Backpressure: last word was from requester 1
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp_rr_vld", 32'(if_rr.out_vld), 32'd1);
      check("bp_rr_idx", 32'(if_rr.out_idx), 32'd1);
      check("bp_rr_dat", 32'(if_rr.out_dat), 32'd1);
      check("bp_rr_rdy", 32'(if_rr.req_rdy), 32'd0);
      check("bp_fp_rdy", 32'(if_fp.req_rdy), 32'd0);
      advance();
    end
    out_rdy = 1'b1;
    settle();
    check("bp_release_rdy", 32'(if_rr.req_rdy), 32'h004);
    advance();
    req_vld = '0;
    settle();
    check("bp_nobubble_vld", 32'(if_rr.out_vld), 32'd1);
    check("bp_nobubble_idx", 32'(if_rr.out_idx), 32'd2);
    advance();

`ifdef MUX_ARB_RR_LOCK_EN
    // Lock on requester 3 (ptr is 3 here)
    req_vld = '1;
    req_lck = 9'h008;
    settle();
    check("lock_beat1", 32'(if_rr.req_rdy), 32'h008);
    advance();
    settle();
    check("lock_beat2", 32'(if_rr.req_rdy), 32'h008);
    advance();
    req_lck = '0;
    settle();
    check("lock_release", 32'(if_rr.req_rdy), 32'h008);
    advance();
    settle();
    check("lock_next", 32'(if_rr.req_rdy), 32'h010);
    advance();
    req_vld = '0;
    settle();
    advance();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_vld = W'($urandom_range(0, (1 << W) - 1));
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < W; i++) begin
        req_dat[i] = 8'($urandom_range(0, 255));
        req_lck[i] = ($urandom_range(0, 7) == 0);
      end
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arb_rr.md
# mux_arb_rr

Registered arbitrating multiplexer: WIDTH requesters with valid/ready handshakes compete for one output channel. Arbitration is either fixed-priority or round-robin. The winner's data is captured into a single output register, tagged with the winner's index. It sits one level above the combinational priority multiplexers, at any point where several streaming sources share one sink.

## Interface
- `DAT_T`, default `logic [8-1:0]`: data type carried per requester.
- `WIDTH`, default `9`: number of requesters, minimum 2.
- `MODE`, default `1`: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.
- `IDX_W`, default `$clog2(WIDTH)`: width of the index output (localparam).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_vld`  in  WIDTH  per-requester valid.
- `req_dat`  in  DAT_T [WIDTH-1:0]  per-requester data.
- `req_rdy`  out  WIDTH  per-requester ready; one-hot or zero.
- `req_lck`  in  WIDTH  per-requester lock request; present only with `MUX_ARB_RR_LOCK_EN`.
- `out_vld`  out  1  output valid.
- `out_dat`  out  DAT_T  output data.
- `out_idx`  out  IDX_W  index of the requester that supplied `out_dat`.
- `out_rdy`  in  1  sink ready.

## Operation
- Registers:
  - output slot: `out_vld`, `out_dat`, `out_idx`;
  - round-robin pointer `ptr`, IDX_W bits;
  - with the macro: `lck_act` and `lck_idx`.
- The slot is free when `!out_vld || out_rdy`.
- Eligible set: `req_vld`, further masked to bit `lck_idx` when `lck_act` is set.
- Grant `g`:
  - MODE 0: lowest-index eligible bit.
  - MODE 1: first eligible bit scanning `ptr`, `ptr+1`, …, `WIDTH-1`, `0`, …, `ptr-1`.
- `req_rdy[g]` is 1 iff the slot is free, the eligible set is non-empty and `rst_n` is high. All other bits are 0.
- An upstream transfer happens when `req_vld[i] && req_rdy[i]`. On transfer:
  - `out_vld` <= 1, `out_dat` <= `req_dat[g]`, `out_idx` <= g.
  - MODE 1 only: `ptr` <= g+1, wrapping WIDTH-1 to 0. `ptr` stays 0 in MODE 0.
- Slot free and no transfer: `out_vld` <= 0. `out_dat` and `out_idx` hold.
- `out_vld && !out_rdy`: all output registers hold and `req_rdy` is all-zero.
- Arithmetic: the `ptr` wrap is an explicit compare against WIDTH-1, so non-power-of-2 WIDTH is legal.

## Timing
- Reset values: `out_vld`=0, `out_dat`='0, `out_idx`=0, `ptr`=0, `lck_act`=0, `lck_idx`=0. `req_rdy`=0 while `rst_n` is low.
- Latency: 1 cycle from upstream transfer to `out_vld`.
- Throughput: 1 transfer per cycle when `out_rdy` is held high.
- `req_rdy` depends combinationally on `req_vld`, `out_rdy` and state. Sources must not make `req_vld` depend on `req_rdy`.
- Requesters must hold `req_vld`/`req_dat` stable until accepted. Arbitration is re-evaluated every cycle, so a pending requester may lose to one with higher priority.
- Simultaneous output accept and upstream transfer in the same cycle: the new word replaces the old one, with no bubble.
- Reset mid-operation: the output word is dropped, the lock is released and `ptr` returns to 0.

## Configuration
- `MUX_ARB_RR_LOCK_EN` defined:
  - The `req_lck` port exists.
  - A transfer from g with `req_lck[g]`=1 sets `lck_act`=1 and `lck_idx`=g.
  - A transfer from `lck_idx` with `req_lck`=0 clears `lck_act`.
  - While locked, only `lck_idx` can be granted, even if it drops `req_vld`. `ptr` still updates per transfer.
- Macro undefined: no `req_lck` port and no lock registers. Arbitration is as above with an unmasked eligible set.

## Test plan
- Reset and idle:
  - Stimulus: reset, then `req_vld`=0.
  - Response: `out_vld`=0, `out_idx`=0, `req_rdy`=0 for 5 cycles.
  - Stimulus: assert `rst_n` low with `out_vld`=1.
  - Response: `out_vld`=0 immediately.
- Fixed priority:
  - Stimulus: MODE 0, `req_vld`=9'h1FF, `out_rdy`=1.
  - Response: every cycle `req_rdy`=9'h001 and `out_idx`=0, with `out_dat` equal to requester 0's data.
- Round-robin fairness:
  - Stimulus: MODE 1, WIDTH 9, all requesters valid, `req_dat[i]`=i.
  - Response: `out_idx` sequence 0,1,…,8,0 on consecutive cycles.
  - Stimulus: `req_vld`=9'b100000100 from `ptr`=0.
  - Response: grants 2,8,2,8.
- Backpressure:
  - Stimulus: `out_rdy`=0 for 3 cycles with `out_vld`=1.
  - Response: `out_dat` and `out_idx` are stable and `req_rdy`=0. The first cycle with `out_rdy`=1 accepts the next word with no bubble.
- Lock (macro defined):
  - Stimulus: requester 3 transfers with `req_lck[3]`=1 for 2 beats while all others are valid.
  - Response: grants 3,3, then the beat with `req_lck[3]`=0 is granted to 3, and the following grant goes to 4.
- Wrap boundary:
  - Stimulus: `ptr`=8 with only requester 0 valid.
  - Response: grant 0 and `ptr` becomes 1.
